mem_arbiter: RTL and testbench

- Shares one single-port backing memory between the core's instruction-fetch port and data-access port.
- Accepts the core's fetch requests (address; held until valid) and data requests (read/write, width, unsigned-extend flag).
- Sequences each access to memory through a req/ack handshake. Generates byte enables and write-lane replication for stores; performs lane extraction and sign/zero extension for loads.
- Sits between the core and the memory model/BRAM wrapper at top level.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports.
// MEM_ARBITER_STARVE_EN adds a starvation counter that forces a fetch grant.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_width,
  input  logic              d_ext,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state_q, state_d;
  logic sel_q, sel_d, ext_q, ext_d, drop_q, drop_d;
  logic [1:0] width_q, width_d, off_q, off_d;
  logic i_valid_q, i_valid_d, d_valid_q, d_valid_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0] mem_be_q, mem_be_d, st_be;
  logic [31:0] mem_wdata_q, mem_wdata_d, st_wdata, ld_data;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic illegal, starve, pick_d, req_now, unused_addr;
  assign unused_addr = ^i_addr[1:0];
`ifdef MEM_ARBITER_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign starve = cnt_q == CW'(STARVE_MAX);
  // Every IDLE arbitration with a waiting fetch either counts a data grant or clears on the fetch grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && i_req) cnt_d = (d_req && !starve) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  logic unused_starve;
  assign unused_starve = STARVE_MAX != 0;
  assign starve = 1'b0;
`endif
  assign pick_d  = d_req && !(starve && i_req);
  assign illegal = d_width == 2'b11 || (d_width == 2'b01 && d_addr[0]) || (d_width == 2'b10 && d_addr[1:0] != 2'b00);
  assign st_wdata = d_width == 2'b00 ? {4{d_wdata[7:0]}} : d_width == 2'b01 ? {2{d_wdata[15:0]}} : d_wdata;
  assign st_be = !d_we ? 4'b1111 : d_width == 2'b00 ? 4'b0001 << d_addr[1:0] :
                 d_width == 2'b01 ? (d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign ld_b = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
  assign ld_data = width_q == 2'b00 ? {{24{!ext_q && ld_b[7]}}, ld_b} :
                   width_q == 2'b01 ? {{16{!ext_q && ld_h[15]}}, ld_h} : mem_rdata;
  assign req_now = sel_q ? d_req : i_req;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ext_d = ext_q;
    width_d = width_q;
    off_d = off_q;
    drop_d = drop_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    d_err_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (pick_d) begin
          sel_d = 1'b1;
          ext_d = d_ext;
          width_d = d_width;
          off_d = d_addr[1:0];
          if (illegal) begin
            d_valid_d = 1'b1;
            d_err_d = 1'b1;
            d_rdata_d = '0;
            state_d = RESP;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d = d_we;
            mem_addr_d = {d_addr[ADDR_W-1:2], 2'b00};
            mem_be_d = st_be;
            mem_wdata_d = st_wdata;
            state_d = ISSUE;
          end
        end else if (i_req) begin
          sel_d = 1'b0;
          mem_req_d = 1'b1;
          mem_we_d = 1'b0;
          mem_addr_d = {i_addr[ADDR_W-1:2], 2'b00};
          mem_be_d = 4'b1111;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A requester dropping req mid-access is a flush: finish the access but stay silent.
        drop_d = drop_q || !req_now;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d = RESP;
          if (!drop_d) begin
            d_valid_d = sel_q;
            i_valid_d = !sel_q;
            d_rdata_d = sel_q ? (mem_we_q ? 32'd0 : ld_data) : d_rdata_q;
            i_rdata_d = sel_q ? i_rdata_q : mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      ext_q <= 1'b0;
      width_q <= '0;
      off_q <= '0;
      drop_q <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      d_err_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ext_q <= ext_d;
      width_q <= width_d;
      off_q <= off_d;
      drop_q <= drop_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      d_err_q <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign i_valid = i_valid_q;
  assign i_rdata = i_rdata_q;
  assign d_valid = d_valid_q;
  assign d_rdata = d_rdata_q;
  assign d_err = d_err_q;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_be = mem_be_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a simple acking memory model.
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, i_valid;
  logic [31:0] i_addr = '0, i_rdata;
  logic d_req = 1'b0, d_we = 1'b0, d_ext = 1'b0, d_valid, d_err;
  logic [1:0] d_width = '0;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  int ack_dly = 0, wait_cnt = 0, vec = 0, errs = 0;
  logic [31:0] mem_word = '0;
  typedef struct {
    logic we; logic [1:0] w; logic e;
    logic [31:0] a, wd, word, rd;
    logic [3:0] be; logic [31:0] mwd; logic err;
  } row_t;
  row_t tbl [11];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_ext(d_ext), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_ack = mem_req && (wait_cnt == ack_dly);
  assign mem_rdata = mem_word;
  always @(posedge clk) wait_cnt <= (rst || !mem_req || mem_ack) ? 0 : wait_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic data_xact(input logic we, input logic [1:0] w, input logic e, input logic [31:0] a, wd, word,
                           output logic got, output logic [31:0] rd, output logic [3:0] be,
                           output logic [31:0] mwd, output logic err, output logic issued);
    mem_word = word; d_we = we; d_width = w; d_ext = e; d_addr = a; d_wdata = wd; d_req = 1'b1;
    got = 1'b0; rd = '0; be = '0; mwd = '0; err = 1'b0; issued = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (mem_req) begin issued = 1'b1; be = mem_be; mwd = mem_wdata; end
      if (d_valid) begin got = 1'b1; rd = d_rdata; err = d_err; end
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1;
    step(); step();
    vec++; if ({mem_req, mem_we, i_valid, d_valid, d_err} !== 5'b0) begin errs++; $display("FAIL reset_ctrl got %b exp 00000", {mem_req, mem_we, i_valid, d_valid, d_err}); end
    vec++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin errs++; $display("FAIL reset_mem got %h exp 0", {mem_addr, mem_be, mem_wdata}); end
    vec++; if ({i_rdata, d_rdata} !== 64'h0) begin errs++; $display("FAIL reset_rdata got %h exp 0", {i_rdata, d_rdata}); end
    i_req = 1'b0; d_req = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    ack_dly = 0; mem_word = 32'h00500093; i_addr = 32'h00400000; i_req = 1'b1;
    step();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL fetch_mem_req got %b exp 1", mem_req); end
    vec++; if (mem_addr !== 32'h00400000) begin errs++; $display("FAIL fetch_addr got %h exp 00400000", mem_addr); end
    vec++; if ({mem_we, mem_be} !== 5'b01111) begin errs++; $display("FAIL fetch_we_be got %b exp 01111", {mem_we, mem_be}); end
    vec++; if (i_valid !== 1'b0) begin errs++; $display("FAIL fetch_early_valid got %b exp 0", i_valid); end
    step();
    vec++; if (i_valid !== 1'b1) begin errs++; $display("FAIL fetch_valid got %b exp 1", i_valid); end
    vec++; if (i_rdata !== 32'h00500093) begin errs++; $display("FAIL fetch_rdata got %h exp 00500093", i_rdata); end
    vec++; if ({mem_req, d_valid} !== 2'b00) begin errs++; $display("FAIL fetch_resp_req got %b exp 00", {mem_req, d_valid}); end
    i_req = 1'b0;
    step();
    vec++; if (i_valid !== 1'b0) begin errs++; $display("FAIL fetch_pulse_len got %b exp 0", i_valid); end
    vec++; if (i_rdata !== 32'h00500093) begin errs++; $display("FAIL fetch_hold got %h exp 00500093", i_rdata); end
  endtask

  task automatic test_priority();
    mem_word = 32'h12345678; i_addr = 32'h00400004; i_req = 1'b1;
    d_we = 1'b0; d_width = 2'b10; d_ext = 1'b0; d_addr = 32'h10010000; d_req = 1'b1;
    step();
    vec++; if (mem_addr !== 32'h10010000) begin errs++; $display("FAIL prio_data_addr got %h exp 10010000", mem_addr); end
    step();
    vec++; if ({d_valid, i_valid} !== 2'b10) begin errs++; $display("FAIL prio_data_valid got %b exp 10", {d_valid, i_valid}); end
    vec++; if (d_rdata !== 32'h12345678) begin errs++; $display("FAIL prio_data_rdata got %h exp 12345678", d_rdata); end
    d_req = 1'b0;
    step();
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL prio_gap got %b exp 0", mem_req); end
    step();
    vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h00400004}) begin errs++; $display("FAIL prio_fetch_issue got %h exp 100400004", {mem_req, mem_addr}); end
    mem_word = 32'h00000013;
    step();
    vec++; if ({i_valid, d_valid, i_rdata} !== {2'b10, 32'h00000013}) begin errs++; $display("FAIL prio_fetch_valid got %h exp 200000013", {i_valid, d_valid, i_rdata}); end
    i_req = 1'b0;
    step();
  endtask

  task automatic test_error();
    d_we = 1'b0; d_width = 2'b01; d_ext = 1'b0; d_addr = 32'h10010001; d_req = 1'b1;
    step();
    vec++; if ({d_valid, d_err, mem_req} !== 3'b110) begin errs++; $display("FAIL err_latency got %b exp 110", {d_valid, d_err, mem_req}); end
    vec++; if (d_rdata !== 32'h0) begin errs++; $display("FAIL err_rdata got %h exp 0", d_rdata); end
    d_req = 1'b0;
    step();
    vec++; if ({d_valid, d_err, mem_req} !== 3'b000) begin errs++; $display("FAIL err_pulse got %b exp 000", {d_valid, d_err, mem_req}); end
    step();
  endtask

  task automatic test_lanes();
    logic got, err, issued;
    logic [31:0] rd, mwd;
    logic [3:0] be;
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 32'h10010003, 32'h000000AB, 32'h0,        32'h0,        4'b1000, 32'hABABABAB, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h10010003, 32'h0,        32'hAB000000, 32'hFFFFFFAB, 4'b1111, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h10010003, 32'h0,        32'hAB000000, 32'h000000AB, 4'b1111, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 32'h10010002, 32'h0000BEEF, 32'h0,        32'h0,        4'b1100, 32'hBEEFBEEF, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b0, 32'h10010002, 32'h0,        32'h80011234, 32'hFFFF8001, 4'b1111, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h10010001, 32'h0,        32'h00007F00, 32'h0000007F, 4'b1111, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 2'b10, 1'b0, 32'h10010004, 32'hCAFEF00D, 32'h0,        32'h0,        4'b1111, 32'hCAFEF00D, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h10010000, 32'h0,        32'h55555555, 32'h0,        4'b0000, 32'h0,        1'b1};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h10010002, 32'h11111111, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 32'h10010000, 32'h0,        32'hFFFF8001, 32'h00008001, 4'b1111, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 32'h10010001, 32'h12345677, 32'h0,        32'h0,        4'b0010, 32'h77777777, 1'b0};
    for (int r = 0; r < 11; r++) begin
      data_xact(tbl[r].we, tbl[r].w, tbl[r].e, tbl[r].a, tbl[r].wd, tbl[r].word, got, rd, be, mwd, err, issued);
      vec++; if (got !== 1'b1) begin errs++; $display("FAIL lane%0d_timeout got %b exp 1", r, got); end
      vec++; if (rd !== tbl[r].rd) begin errs++; $display("FAIL lane%0d_rdata got %h exp %h", r, rd, tbl[r].rd); end
      vec++; if ({err, issued} !== {tbl[r].err, !tbl[r].err}) begin errs++; $display("FAIL lane%0d_err_issue got %b exp %b", r, {err, issued}, {tbl[r].err, !tbl[r].err}); end
      if (!tbl[r].err) begin
        vec++; if (be !== tbl[r].be) begin errs++; $display("FAIL lane%0d_be got %b exp %b", r, be, tbl[r].be); end
      end
      if (tbl[r].we && !tbl[r].err) begin
        vec++; if (mwd !== tbl[r].mwd) begin errs++; $display("FAIL lane%0d_wdata got %h exp %h", r, mwd, tbl[r].mwd); end
      end
    end
  endtask

  task automatic test_withdraw();
    int hi, iv;
    ack_dly = 5; mem_word = 32'hDEADBEEF; i_addr = 32'h00400008; i_req = 1'b1;
    step();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL wd_issue got %b exp 1", mem_req); end
    i_req = 1'b0; hi = 1; iv = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (i_valid) iv++;
      if (!mem_req) break;
      hi++;
    end
    vec++; if (hi !== 6) begin errs++; $display("FAIL wd_req_cycles got %0d exp 6", hi); end
    step();
    if (i_valid) iv++;
    vec++; if (iv !== 0) begin errs++; $display("FAIL wd_valid_suppressed got %0d exp 0", iv); end
    ack_dly = 0; mem_word = 32'h00000073; i_addr = 32'h0040000C; i_req = 1'b1;
    step();
    vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h0040000C}) begin errs++; $display("FAIL wd_idle_regrant got %h exp 10040000c", {mem_req, mem_addr}); end
    step();
    vec++; if ({i_valid, i_rdata} !== {1'b1, 32'h00000073}) begin errs++; $display("FAIL wd_after_fetch got %h exp 100000073", {i_valid, i_rdata}); end
    i_req = 1'b0;
    step();
    ack_dly = 5; i_req = 1'b1;
    step(); step();
    rst = 1'b1; i_req = 1'b0;
    step();
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL wd_reset_abandon got %b exp 0", mem_req); end
    rst = 1'b0; ack_dly = 0;
    step();
  endtask

  task automatic test_starve();
    int nd, ni;
    rst = 1'b1; step(); rst = 1'b0;
    mem_word = 32'h0000CAFE; i_addr = 32'h00400010; i_req = 1'b1;
    d_we = 1'b0; d_width = 2'b10; d_ext = 1'b0; d_addr = 32'h10010000; d_req = 1'b1;
    nd = 0; ni = 0;
    for (int k = 0; k < 40 && ni == 0; k++) begin
      step();
      if (d_valid) nd++;
      if (i_valid) ni++;
    end
`ifdef MEM_ARBITER_STARVE_EN
    vec++; if ({ni, nd} !== {32'd1, 32'd4}) begin errs++; $display("FAIL starve_first i_valid=%0d d_valid=%0d exp 1 and 4", ni, nd); end
    nd = 0; ni = 0;
    for (int k = 0; k < 40 && ni == 0; k++) begin
      step();
      if (d_valid) nd++;
      if (i_valid) ni++;
    end
    vec++; if ({ni, nd} !== {32'd1, 32'd4}) begin errs++; $display("FAIL starve_cleared i_valid=%0d d_valid=%0d exp 1 and 4", ni, nd); end
`else
    vec++; if (ni !== 0) begin errs++; $display("FAIL strict_prio got %0d i_valid exp 0", ni); end
    vec++; if (nd < 10) begin errs++; $display("FAIL strict_data got %0d d_valid exp >=10", nd); end
`endif
    i_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_error();
    test_lanes();
    test_withdraw();
    test_starve();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
